// File: rtl/cpl_enqueue_arbiter.sv
// Round-robin front end for the completion queue manager's enqueue port:
// request/commit arbitration, tag-routed responses and per-port budget counters.
module cpl_enqueue_arbiter #(
    parameter int PORTS             = 4,
    parameter int QUEUE_INDEX_WIDTH = 5,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int OP_TAG_WIDTH      = 6,
    parameter int ADDR_WIDTH        = 64,
    parameter int MAX_OUTSTANDING   = 8,
    localparam int PW = $clog2(PORTS),
    localparam int CW = $clog2(MAX_OUTSTANDING + 1),
    localparam int TW = REQ_TAG_WIDTH + PW
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0]   s_req_queue,
    input  logic [PORTS*REQ_TAG_WIDTH-1:0]       s_req_tag,
    input  logic [PORTS-1:0]                     s_req_valid,
    output logic [PORTS-1:0]                     s_req_ready,
    output logic [QUEUE_INDEX_WIDTH-1:0]         m_axis_enqueue_req_queue,
    output logic [TW-1:0]                        m_axis_enqueue_req_tag,
    output logic                                 m_axis_enqueue_req_valid,
    input  logic                                 m_axis_enqueue_req_ready,
    input  logic [TW-1:0]                        s_axis_enqueue_resp_tag,
    input  logic [ADDR_WIDTH-1:0]                s_axis_enqueue_resp_addr,
    input  logic [OP_TAG_WIDTH-1:0]              s_axis_enqueue_resp_op_tag,
    input  logic                                 s_axis_enqueue_resp_full,
    input  logic                                 s_axis_enqueue_resp_error,
    input  logic                                 s_axis_enqueue_resp_valid,
    output logic                                 s_axis_enqueue_resp_ready,
    output logic [REQ_TAG_WIDTH-1:0]             m_resp_tag,
    output logic [ADDR_WIDTH-1:0]                m_resp_addr,
    output logic [OP_TAG_WIDTH-1:0]              m_resp_op_tag,
    output logic                                 m_resp_full,
    output logic                                 m_resp_error,
    output logic [PORTS-1:0]                     m_resp_valid,
    input  logic [PORTS-1:0]                     m_resp_ready,
    input  logic [PORTS*OP_TAG_WIDTH-1:0]        s_commit_op_tag,
    input  logic [PORTS-1:0]                     s_commit_valid,
    output logic [PORTS-1:0]                     s_commit_ready,
    output logic [OP_TAG_WIDTH-1:0]              m_axis_enqueue_commit_op_tag,
    output logic                                 m_axis_enqueue_commit_valid,
    output logic [PORTS*CW-1:0]                  outstanding,
    output logic                                 err_underflow
);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic                         req_valid_q;
    logic [QUEUE_INDEX_WIDTH-1:0] req_queue_q;
    logic [TW-1:0]                req_tag_q;
    logic [PW-1:0]                req_rr_q;
    logic                         resp_valid_q;
    logic [PW-1:0]                resp_dest_q;
    logic [REQ_TAG_WIDTH-1:0]     resp_tag_q;
    logic [ADDR_WIDTH-1:0]        resp_addr_q;
    logic [OP_TAG_WIDTH-1:0]      resp_op_tag_q;
    logic                         resp_full_q;
    logic                         resp_error_q;
    logic                         cmt_valid_q;
    logic [OP_TAG_WIDTH-1:0]      cmt_op_tag_q;
    logic [PW-1:0]                cmt_rr_q;
    logic [CW-1:0]                cnt_q [PORTS];
    logic [CW-1:0]                cnt_d [PORTS];
    logic                         underflow_q;
    logic                         underflow_d;

    logic [PORTS-1:0] req_elig;
    logic             req_found, req_grant, cmt_found, cmt_grant;
    logic [PW-1:0]    req_sel, cmt_sel;
    logic             resp_deliver, resp_load, resp_retire;
    logic [CW+1:0]    cnt_sum, cnt_dec;

    always_comb begin
        req_elig = '0;
        for (int p = 0; p < PORTS; p++) begin
            req_elig[p] = s_req_valid[p] && (cnt_q[p] < MAX_CNT);
        end
    end

    // Search starts one past the last grant; PORTS is a power of two so the add wraps.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        cmt_found = 1'b0;
        cmt_sel   = '0;
        for (int i = 1; i <= PORTS; i++) begin
            if (!req_found && req_elig[req_rr_q + PW'(i)]) begin
                req_found = 1'b1;
                req_sel   = req_rr_q + PW'(i);
            end
            if (!cmt_found && s_commit_valid[cmt_rr_q + PW'(i)]) begin
                cmt_found = 1'b1;
                cmt_sel   = cmt_rr_q + PW'(i);
            end
        end
    end

    assign req_grant    = rst_n && enable && (!req_valid_q || m_axis_enqueue_req_ready) && req_found;
    assign cmt_grant    = rst_n && cmt_found;
    assign resp_deliver = resp_valid_q && m_resp_ready[resp_dest_q];
    assign resp_load    = rst_n && (!resp_valid_q || resp_deliver);
    assign resp_retire  = resp_deliver && (resp_full_q || resp_error_q);

    always_comb begin
        s_req_ready                 = '0;
        s_req_ready[req_sel]        = req_grant;
        s_commit_ready              = '0;
        s_commit_ready[cmt_sel]     = cmt_grant;
        m_resp_valid                = '0;
        m_resp_valid[resp_dest_q]   = resp_valid_q;
    end

    // A full/error response retires its op directly since no commit will follow.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = 1'b0;
        cnt_sum     = '0;
        cnt_dec     = '0;
        for (int p = 0; p < PORTS; p++) begin
            cnt_sum = {2'b00, cnt_q[p]} + (CW+2)'(req_grant && (req_sel == PW'(p)));
            cnt_dec = (CW+2)'(cmt_grant && (cmt_sel == PW'(p)))
                    + (CW+2)'(resp_retire && (resp_dest_q == PW'(p)));
            if (cnt_sum < cnt_dec) begin
                cnt_d[p]    = '0;
                underflow_d = 1'b1;
            end else begin
                cnt_d[p] = CW'(cnt_sum - cnt_dec);
            end
        end
    end

    always_comb begin
        outstanding = '0;
        for (int p = 0; p < PORTS; p++) begin
            outstanding[p*CW +: CW] = cnt_q[p];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_valid_q   <= 1'b0;
            req_queue_q   <= '0;
            req_tag_q     <= '0;
            req_rr_q      <= PW'(PORTS - 1);
            resp_valid_q  <= 1'b0;
            resp_dest_q   <= '0;
            resp_tag_q    <= '0;
            resp_addr_q   <= '0;
            resp_op_tag_q <= '0;
            resp_full_q   <= 1'b0;
            resp_error_q  <= 1'b0;
            cmt_valid_q   <= 1'b0;
            cmt_op_tag_q  <= '0;
            cmt_rr_q      <= PW'(PORTS - 1);
            underflow_q   <= 1'b0;
            for (int p = 0; p < PORTS; p++) cnt_q[p] <= '0;
        end else begin
            if (req_grant) begin
                req_valid_q <= 1'b1;
                req_queue_q <= s_req_queue[req_sel*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
                req_tag_q   <= {req_sel, s_req_tag[req_sel*REQ_TAG_WIDTH +: REQ_TAG_WIDTH]};
                req_rr_q    <= req_sel;
            end else if (m_axis_enqueue_req_ready) begin
                req_valid_q <= 1'b0;
            end

            if (resp_load && s_axis_enqueue_resp_valid) begin
                resp_valid_q  <= 1'b1;
                resp_dest_q   <= s_axis_enqueue_resp_tag[TW-1 -: PW];
                resp_tag_q    <= s_axis_enqueue_resp_tag[REQ_TAG_WIDTH-1:0];
                resp_addr_q   <= s_axis_enqueue_resp_addr;
                resp_op_tag_q <= s_axis_enqueue_resp_op_tag;
                resp_full_q   <= s_axis_enqueue_resp_full;
                resp_error_q  <= s_axis_enqueue_resp_error;
            end else if (resp_deliver) begin
                resp_valid_q <= 1'b0;
            end

            cmt_valid_q <= cmt_grant;
            if (cmt_grant) begin
                cmt_op_tag_q <= s_commit_op_tag[cmt_sel*OP_TAG_WIDTH +: OP_TAG_WIDTH];
                cmt_rr_q     <= cmt_sel;
            end

            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign m_axis_enqueue_req_valid     = req_valid_q;
    assign m_axis_enqueue_req_queue     = req_queue_q;
    assign m_axis_enqueue_req_tag       = req_tag_q;
    assign s_axis_enqueue_resp_ready    = resp_load;
    assign m_resp_tag                   = resp_tag_q;
    assign m_resp_addr                  = resp_addr_q;
    assign m_resp_op_tag                = resp_op_tag_q;
    assign m_resp_full                  = resp_full_q;
    assign m_resp_error                 = resp_error_q;
    assign m_axis_enqueue_commit_valid  = cmt_valid_q;
    assign m_axis_enqueue_commit_op_tag = cmt_op_tag_q;
    assign err_underflow                = underflow_q;

endmodule

// File: tb/tb_cpl_enqueue_arbiter.sv
// Bench for cpl_enqueue_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_cpl_enqueue_arbiter;
    localparam int P = 4, QW = 5, RTW = 8, OTW = 6, AW = 64, MAXO = 8;
    localparam int PW = 2, CW = 4, TW = RTW + PW;

    logic            clk = 1'b0;
    logic            rst_n, enable;
    logic [P*QW-1:0] s_req_queue;
    logic [P*RTW-1:0] s_req_tag;
    logic [P-1:0]    s_req_valid, s_req_ready;
    logic [QW-1:0]   m_axis_enqueue_req_queue;
    logic [TW-1:0]   m_axis_enqueue_req_tag;
    logic            m_axis_enqueue_req_valid, m_axis_enqueue_req_ready;
    logic [TW-1:0]   s_axis_enqueue_resp_tag;
    logic [AW-1:0]   s_axis_enqueue_resp_addr;
    logic [OTW-1:0]  s_axis_enqueue_resp_op_tag;
    logic            s_axis_enqueue_resp_full, s_axis_enqueue_resp_error;
    logic            s_axis_enqueue_resp_valid, s_axis_enqueue_resp_ready;
    logic [RTW-1:0]  m_resp_tag;
    logic [AW-1:0]   m_resp_addr;
    logic [OTW-1:0]  m_resp_op_tag;
    logic            m_resp_full, m_resp_error;
    logic [P-1:0]    m_resp_valid, m_resp_ready;
    logic [P*OTW-1:0] s_commit_op_tag;
    logic [P-1:0]    s_commit_valid, s_commit_ready;
    logic [OTW-1:0]  m_axis_enqueue_commit_op_tag;
    logic            m_axis_enqueue_commit_valid;
    logic [P*CW-1:0] outstanding;
    logic            err_underflow;

    always #5 clk = ~clk;

    cpl_enqueue_arbiter #(
        .PORTS(P), .QUEUE_INDEX_WIDTH(QW), .REQ_TAG_WIDTH(RTW), .OP_TAG_WIDTH(OTW),
        .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_req_queue(s_req_queue), .s_req_tag(s_req_tag),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .m_axis_enqueue_req_queue(m_axis_enqueue_req_queue),
        .m_axis_enqueue_req_tag(m_axis_enqueue_req_tag),
        .m_axis_enqueue_req_valid(m_axis_enqueue_req_valid),
        .m_axis_enqueue_req_ready(m_axis_enqueue_req_ready),
        .s_axis_enqueue_resp_tag(s_axis_enqueue_resp_tag),
        .s_axis_enqueue_resp_addr(s_axis_enqueue_resp_addr),
        .s_axis_enqueue_resp_op_tag(s_axis_enqueue_resp_op_tag),
        .s_axis_enqueue_resp_full(s_axis_enqueue_resp_full),
        .s_axis_enqueue_resp_error(s_axis_enqueue_resp_error),
        .s_axis_enqueue_resp_valid(s_axis_enqueue_resp_valid),
        .s_axis_enqueue_resp_ready(s_axis_enqueue_resp_ready),
        .m_resp_tag(m_resp_tag), .m_resp_addr(m_resp_addr), .m_resp_op_tag(m_resp_op_tag),
        .m_resp_full(m_resp_full), .m_resp_error(m_resp_error),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .s_commit_op_tag(s_commit_op_tag), .s_commit_valid(s_commit_valid),
        .s_commit_ready(s_commit_ready),
        .m_axis_enqueue_commit_op_tag(m_axis_enqueue_commit_op_tag),
        .m_axis_enqueue_commit_valid(m_axis_enqueue_commit_valid),
        .outstanding(outstanding), .err_underflow(err_underflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model state: counts as integers, stages as plain held records.
    int          m_cnt [P];
    int          m_last_req, m_last_cmt;
    bit          mq_v;
    logic [QW-1:0] mq_queue;
    logic [TW-1:0] mq_tag;
    bit          mr_v;
    int          mr_dest;
    logic [RTW-1:0] mr_tag;
    logic [AW-1:0]  mr_addr;
    logic [OTW-1:0] mr_op;
    bit          mr_full, mr_err;
    bit          mc_v;
    logic [OTW-1:0] mc_tag;
    bit          m_uf;

    task automatic model_reset();
        for (int p = 0; p < P; p++) m_cnt[p] = 0;
        m_last_req = P - 1;
        m_last_cmt = P - 1;
        mq_v = 0; mq_queue = '0; mq_tag = '0;
        mr_v = 0; mr_dest = 0; mr_tag = '0; mr_addr = '0; mr_op = '0; mr_full = 0; mr_err = 0;
        mc_v = 0; mc_tag = '0; m_uf = 0;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        int gp, cp, n, pp;
        bit deliver, rready, uf;
        logic [P-1:0] exp_sr, exp_cr, exp_mv;
        #1;
        gp = -1;
        cp = -1;
        if (rst_n && enable && (!mq_v || m_axis_enqueue_req_ready))
            for (int k = 1; k <= P; k++) begin
                pp = (m_last_req + k) % P;
                if (gp < 0 && s_req_valid[pp] && m_cnt[pp] < MAXO) gp = pp;
            end
        if (rst_n)
            for (int k = 1; k <= P; k++) begin
                pp = (m_last_cmt + k) % P;
                if (cp < 0 && s_commit_valid[pp]) cp = pp;
            end
        deliver = mr_v && m_resp_ready[mr_dest];
        rready  = rst_n && (!mr_v || deliver);
        exp_sr = '0; if (gp >= 0) exp_sr[gp] = 1'b1;
        exp_cr = '0; if (cp >= 0) exp_cr[cp] = 1'b1;
        exp_mv = '0; if (mr_v) exp_mv[mr_dest] = 1'b1;

        check("s_req_ready", s_req_ready, exp_sr);
        check("s_commit_ready", s_commit_ready, exp_cr);
        check("resp_ready", s_axis_enqueue_resp_ready, rready);
        check("req_valid", m_axis_enqueue_req_valid, mq_v);
        check("req_queue", m_axis_enqueue_req_queue, mq_queue);
        check("req_tag", m_axis_enqueue_req_tag, mq_tag);
        check("m_resp_valid", m_resp_valid, exp_mv);
        check("m_resp_tag", m_resp_tag, mr_tag);
        check("m_resp_addr", m_resp_addr, mr_addr);
        check("m_resp_op_tag", m_resp_op_tag, mr_op);
        check("m_resp_flags", {m_resp_full, m_resp_error}, {mr_full, mr_err});
        check("commit_valid", m_axis_enqueue_commit_valid, mc_v);
        check("commit_op_tag", m_axis_enqueue_commit_op_tag, mc_tag);
        for (int p = 0; p < P; p++)
            check($sformatf("outstanding[%0d]", p), outstanding[p*CW +: CW], m_cnt[p]);
        check("err_underflow", err_underflow, m_uf);

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            uf = 0;
            for (int p = 0; p < P; p++) begin
                n = m_cnt[p] + int'(gp == p) - int'(cp == p)
                    - int'(deliver && mr_dest == p && (mr_full || mr_err));
                if (n < 0) begin uf = 1; n = 0; end
                m_cnt[p] = n;
            end
            m_uf = uf;
            if (gp >= 0) begin
                mq_v = 1;
                mq_queue = s_req_queue[gp*QW +: QW];
                mq_tag = {2'(gp), s_req_tag[gp*RTW +: RTW]};
                m_last_req = gp;
            end else if (m_axis_enqueue_req_ready) begin
                mq_v = 0;
            end
            if (rready && s_axis_enqueue_resp_valid) begin
                mr_v = 1;
                mr_dest = int'(s_axis_enqueue_resp_tag[TW-1:RTW]);
                mr_tag = s_axis_enqueue_resp_tag[RTW-1:0];
                mr_addr = s_axis_enqueue_resp_addr;
                mr_op = s_axis_enqueue_resp_op_tag;
                mr_full = s_axis_enqueue_resp_full;
                mr_err = s_axis_enqueue_resp_error;
            end else if (deliver) begin
                mr_v = 0;
            end
            mc_v = (cp >= 0);
            if (cp >= 0) begin
                mc_tag = s_commit_op_tag[cp*OTW +: OTW];
                m_last_cmt = cp;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_idle();
        enable = 1'b1;
        s_req_valid = '0; s_commit_valid = '0; m_resp_ready = '0;
        s_axis_enqueue_resp_valid = 1'b0;
        m_axis_enqueue_req_ready = 1'b1;
    endtask

    task automatic drive_rand(input int req_pct, input int rdy_pct, input int rsp_pct,
                              input int cmt_pct, input int en_pct);
        for (int p = 0; p < P; p++) begin
            s_req_valid[p]          = ($urandom_range(99) < req_pct);
            s_req_queue[p*QW +: QW] = QW'($urandom);
            s_req_tag[p*RTW +: RTW] = RTW'($urandom);
            s_commit_valid[p]       = ($urandom_range(99) < cmt_pct);
            s_commit_op_tag[p*OTW +: OTW] = OTW'($urandom);
            m_resp_ready[p]         = ($urandom_range(99) < rdy_pct);
        end
        m_axis_enqueue_req_ready   = ($urandom_range(99) < rdy_pct);
        enable                     = ($urandom_range(99) < en_pct);
        s_axis_enqueue_resp_valid  = ($urandom_range(99) < rsp_pct);
        s_axis_enqueue_resp_tag    = TW'($urandom);
        s_axis_enqueue_resp_addr   = {$urandom, $urandom};
        s_axis_enqueue_resp_op_tag = OTW'($urandom);
        s_axis_enqueue_resp_full   = ($urandom_range(3) == 0);
        s_axis_enqueue_resp_error  = ($urandom_range(7) == 0);
    endtask

    initial begin
        rst_n = 1'b0;
        s_req_queue = '0; s_req_tag = '0; s_commit_op_tag = '0;
        s_axis_enqueue_resp_tag = '0; s_axis_enqueue_resp_addr = '0;
        s_axis_enqueue_resp_op_tag = '0; s_axis_enqueue_resp_full = 1'b0;
        s_axis_enqueue_resp_error = 1'b0;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        model_reset();
        step();
        step();

        // Round-robin with every port requesting
        rst_n = 1'b1;
        s_req_valid = '1;
        for (int p = 0; p < P; p++) s_req_tag[p*RTW +: RTW] = RTW'(8'h10 + p);
        for (int i = 0; i < 8; i++) begin
            #1 check("rr_grant", s_req_ready, 4'b0001 << (i % 4));
            if (i > 0) check("rr_tag_port", m_axis_enqueue_req_tag[TW-1:RTW], (i - 1) % 4);
            step();
        end
        rst_n = 1'b0; drive_idle(); step(); rst_n = 1'b1;

        // Port 2 alone fills its budget
        s_req_valid = 4'b0100;
        for (int i = 0; i < 10; i++) step();
        #1 check("budget_cnt", outstanding[2*CW +: CW], MAXO);
        check("budget_block", s_req_ready, 0);
        s_commit_valid = 4'b0100;
        s_commit_op_tag = {P*OTW{1'b1}};
        step();
        s_commit_valid = '0;
        for (int i = 0; i < 3; i++) step();
        s_req_valid = '0;

        // Response routing and retirement by a full response
        s_req_valid = 4'b1000; step(); s_req_valid = '0;
        s_axis_enqueue_resp_tag = {2'd3, 8'h5A};
        s_axis_enqueue_resp_full = 1'b1;
        s_axis_enqueue_resp_valid = 1'b1;
        step();
        s_axis_enqueue_resp_valid = 1'b0;
        #1 check("route_valid", m_resp_valid, 4'b1000);
        check("route_tag", m_resp_tag, 8'h5A);
        step();
        m_resp_ready = 4'b1000;
        step();
        m_resp_ready = '0;
        #1 check("route_retire", outstanding[3*CW +: CW], 0);
        check("route_no_uf", err_underflow, 0);

        // Simultaneous grant and commit on port 1, then a commit at zero
        s_req_valid = 4'b0010; step();
        s_commit_valid = 4'b0010; step();
        s_req_valid = '0; s_commit_valid = '0;
        #1 check("simul_cnt", outstanding[1*CW +: CW], 1);
        s_commit_valid = 4'b0001; step(); s_commit_valid = '0;
        #1 check("uf_pulse", err_underflow, 1);
        check("uf_clamp", outstanding[CW-1:0], 0);
        step();
        #1 check("uf_once", err_underflow, 0);

        // Random traffic with occasional mid-operation resets
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 600; c++) begin
                case (ph)
                    0:       drive_rand(80, 90, 50, 30, 95);
                    1:       drive_rand(90, 20, 60, 20, 90);
                    2:       drive_rand(90, 80, 10, 5, 100);
                    default: drive_rand(60, 60, 60, 60, 50);
                endcase
                rst_n = ($urandom_range(299) != 0);
                step();
            end
        end
        rst_n = 1'b0; drive_idle(); step();
        rst_n = 1'b1; s_req_valid = '1;
        #1 check("post_reset_port0", s_req_ready, 4'b0001);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
